alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Registered, parametrised successor to the combinational ALU-control decoder.
- Accepts one instruction per valid/ready handshake and decodes opcode/opext into an ALU control code.
- Immediate shifts (lshi) can be expanded into a sequence of single-bit shift beats, so a narrow ALU shifter can be used.
- Sits between the instruction register and the ALU/regfile write-back control; every output is registered.

Parameters:
- OP_W, 4, opcode width
- EXT_W, 4, opext width
- CTRL_W, 4, alucont width (must be >= 4)
- SHAMT_W, 4, shift-amount magnitude width; maximum step count is 2^SHAMT_W-1
- MULTI_STEP_SHIFT, 1, 1 = expand lshi into single-bit beats; 0 = issue lshi as one beat

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  sequencer will accept an instruction this cycle
- opcode  in  OP_W  instruction opcode
- opext  in  EXT_W  opcode extension / R-type function
- imm  in  SHAMT_W+1  immediate; [SHAMT_W] is direction (0 = left, 1 = right), [SHAMT_W-1:0] is magnitude
- out_valid  out  1  control beat present
- out_ready  in  1  downstream accepts the beat
- alucont  out  CTRL_W  ALU control code, zero-extended to CTRL_W
- shift_right  out  1  direction for shift beats; 0 otherwise
- out_last  out  1  final beat of the instruction
- illegal  out  1  opcode/opext undecodable; alucont=0 on that beat

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, out_valid=0, alucont=0, shift_right=0, out_last=0, illegal=0, step counter=0. Reset asserted mid-sequence aborts it; no further beats are issued.
- Decode, I-type (on the opcode):
  - 0101 -> 0000; 1001 -> 0001; 0001 -> 0010; 0011 -> 0011; 0010 -> 0100; 1011 -> 0101; 1101 -> 0110; 1111 -> 1001.
  - 1000 with opext=0100 -> 0111 (lsh). Opcode 1000 with any other opext -> 1000 (lshi).
- Decode, R-type (opcode 0000, on opext): 0101/1001/0001/0011/0010/1011/1101 map as the I-type table; 0100 -> 1111 (movri).
- Any other opcode/opext: alucont=0000, illegal=1, single beat.
- New code 1010 (SHIFT1): single-bit shift in the direction given by shift_right.
- Handshake: an instruction is accepted when in_valid & in_ready. A beat is transferred when out_valid & out_ready. While out_valid=1 and out_ready=0, all outputs are held stable.
- in_ready = (state==IDLE) & (!out_valid | (out_ready & out_last)). This gives back-to-back single-beat instructions with no bubble.
- Latency: the first beat is valid on the cycle after acceptance.
- FSM IDLE: on accept, load the output register with the decoded beat.
  - lshi with MULTI_STEP_SHIFT=1 and magnitude N>=2: first beat is SHIFT1, out_last=0, counter=N-1, go to SHIFT.
  - N=1: one SHIFT1 beat with out_last=1.
  - N=0: one beat of code 1000 with out_last=1.
  - All other instructions: single beat with out_last=1.
- FSM SHIFT: on each transferred beat, decrement the counter and present the next SHIFT1 beat; out_last=1 when the counter reaches 1. When the last beat transfers, go to IDLE.
- lsh (register amount) is never expanded: single beat 0111.
- MULTI_STEP_SHIFT=0: lshi is a single beat of 1000 with out_last=1.
- shift_right is driven from imm[SHAMT_W] only for SHIFT1/1000 beats; 0 otherwise.
- When no instruction is accepted and the last beat has transferred, out_valid drops to 0 the next cycle.
- Maximum magnitude (2^SHAMT_W-1) produces exactly that many beats. The counter never wraps.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - opcode constants (OP_ADDI..OP_LUI, OP_RTYPE=0000)
  - ALU code constants (ALU_ADD=0000 .. ALU_MOVRI=1111, ALU_SHIFT1=1010)
  - state encoding (IDLE, SHIFT)
- One combinational sub-module, alu_ctrl_decode: maps (opcode, opext) to (code, illegal, is_lshi). It is instantiated inside the sequencer.

Test Plan:
- Reset released; addi (0101) accepted with out_ready=1 -> next cycle out_valid=1, alucont=0000, out_last=1, illegal=0.
- R-type opext=0100 followed by opcode 1011 back-to-back, out_ready=1 -> beats 1111 then 0101 on consecutive cycles; in_ready stays 1.
- lshi imm={1,0011}, out_ready=1 -> three beats of 1010 with shift_right=1; out_last only on the third; in_ready=0 until the third transfers.
- lshi imm={0,0000} -> one beat of 1000 with out_last=1. lsh (opcode 1000, opext 0100) with imm=1111 -> one beat of 0111.
- out_ready held 0 for 4 cycles during the second beat of a 5-step shift -> outputs stable; total beats=5. Then reset pulsed low mid-sequence -> out_valid=0 immediately, in_ready=1 after release.
- Opcode 0111 -> illegal=1, alucont=0000, out_last=1. MULTI_STEP_SHIFT=0 build, lshi imm={0,1111} -> single beat of 1000.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU-control sequencer: opcodes, R-type functions,
// ALU control codes and FSM state encoding.
package alu_ctrl_pkg;

    localparam int unsigned ALU_W = 4;

    // I-type opcodes (R-type uses OP_RTYPE and decodes on opext)
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0011;
    localparam logic [3:0] OP_XORI  = 4'b0010;
    localparam logic [3:0] OP_SLTI  = 4'b1011;
    localparam logic [3:0] OP_SLTUI = 4'b1101;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // opext values with special meaning
    localparam logic [3:0] EXT_LSH   = 4'b0100;
    localparam logic [3:0] EXT_MOVRI = 4'b0100;

    // ALU control codes
    localparam logic [ALU_W-1:0] ALU_ADD    = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB    = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_AND    = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_OR     = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_XOR    = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SLT    = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SLTU   = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_LSH    = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_LSHI   = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_LUI    = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_SHIFT1 = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_MOVRI  = 4'b1111;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/opext -> ALU control decoder.
// Ports:
//   i_opcode    instruction opcode
//   i_opext     opcode extension / R-type function
//   o_code_c    ALU control code (0 when illegal)
//   o_illegal_c opcode/opext undecodable
//   o_is_lshi_c instruction is an immediate shift (candidate for expansion)
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned OP_W  = 4,
    parameter int unsigned EXT_W = 4
) (
    input  logic [OP_W-1:0]  i_opcode,
    input  logic [EXT_W-1:0] i_opext,
    output logic [ALU_W-1:0] o_code_c,
    output logic             o_illegal_c,
    output logic             o_is_lshi_c
);

    // Two-level decode: opcode first, R-type falls through to opext
    always_comb begin
        o_code_c    = ALU_ADD;
        o_illegal_c = 1'b0;
        o_is_lshi_c = 1'b0;
        case (i_opcode)
            OP_W'(OP_ADDI):  o_code_c = ALU_ADD;
            OP_W'(OP_SUBI):  o_code_c = ALU_SUB;
            OP_W'(OP_ANDI):  o_code_c = ALU_AND;
            OP_W'(OP_ORI):   o_code_c = ALU_OR;
            OP_W'(OP_XORI):  o_code_c = ALU_XOR;
            OP_W'(OP_SLTI):  o_code_c = ALU_SLT;
            OP_W'(OP_SLTUI): o_code_c = ALU_SLTU;
            OP_W'(OP_LUI):   o_code_c = ALU_LUI;
            OP_W'(OP_SHIFT): begin
                // register-amount shift is never expanded
                if (i_opext == EXT_W'(EXT_LSH)) begin
                    o_code_c = ALU_LSH;
                end else begin
                    o_code_c    = ALU_LSHI;
                    o_is_lshi_c = 1'b1;
                end
            end
            OP_W'(OP_RTYPE): begin
                case (i_opext)
                    EXT_W'(OP_ADDI):   o_code_c = ALU_ADD;
                    EXT_W'(OP_SUBI):   o_code_c = ALU_SUB;
                    EXT_W'(OP_ANDI):   o_code_c = ALU_AND;
                    EXT_W'(OP_ORI):    o_code_c = ALU_OR;
                    EXT_W'(OP_XORI):   o_code_c = ALU_XOR;
                    EXT_W'(OP_SLTI):   o_code_c = ALU_SLT;
                    EXT_W'(OP_SLTUI):  o_code_c = ALU_SLTU;
                    EXT_W'(EXT_MOVRI): o_code_c = ALU_MOVRI;
                    default:           o_illegal_c = 1'b1;
                endcase
            end
            default: o_illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control sequencer. Accepts one instruction per valid/ready
// handshake, decodes it and emits one or more registered control beats.
// Immediate shifts can be expanded into single-bit SHIFT1 beats.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   in_valid/in_ready   instruction handshake
//   opcode, opext, imm  instruction fields; imm[SHAMT_W] = direction
//   out_valid/out_ready control-beat handshake
//   alucont             ALU control code (zero-extended)
//   shift_right         shift direction on shift beats, 0 otherwise
//   out_last            final beat of the instruction
//   illegal             undecodable instruction (alucont = 0)
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned OP_W             = 4,
    parameter int unsigned EXT_W            = 4,
    parameter int unsigned CTRL_W           = 4,
    parameter int unsigned SHAMT_W          = 4,
    parameter bit          MULTI_STEP_SHIFT = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    opcode,
    input  logic [EXT_W-1:0]   opext,
    input  logic [SHAMT_W:0]   imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alucont,
    output logic               shift_right,
    output logic               out_last,
    output logic               illegal
);

    logic [0:0]         r_state,   w_state_nxt;
    logic [SHAMT_W-1:0] r_cnt,     w_cnt_nxt;
    logic               r_valid,   w_valid_nxt;
    logic [ALU_W-1:0]   r_code,    w_code_nxt;
    logic               r_right,   w_right_nxt;
    logic               r_last,    w_last_nxt;
    logic               r_illegal, w_illegal_nxt;

    logic [ALU_W-1:0]   w_dec_code;
    logic               w_dec_illegal;
    logic               w_dec_is_lshi;
    logic               w_accept;
    logic               w_xfer;
    logic [SHAMT_W-1:0] w_mag;
    logic               w_dir;

    alu_ctrl_decode #(
        .OP_W  (OP_W),
        .EXT_W (EXT_W)
    ) u_decode (
        .i_opcode    (opcode),
        .i_opext     (opext),
        .o_code_c    (w_dec_code),
        .o_illegal_c (w_dec_illegal),
        .o_is_lshi_c (w_dec_is_lshi)
    );

    // Accept only when idle and the current beat (if any) is leaving as the last
    assign in_ready = (r_state == ST_IDLE) & (~r_valid | (out_ready & r_last));
    assign w_accept = in_valid & in_ready;
    assign w_xfer   = r_valid & out_ready;
    assign w_mag    = imm[SHAMT_W-1:0];
    assign w_dir    = imm[SHAMT_W];

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_code    <= '0;
            r_right   <= 1'b0;
            r_last    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_valid   <= w_valid_nxt;
            r_code    <= w_code_nxt;
            r_right   <= w_right_nxt;
            r_last    <= w_last_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    // Next-state and next-beat logic; r_cnt counts beats still to follow
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_valid_nxt   = r_valid;
        w_code_nxt    = r_code;
        w_right_nxt   = r_right;
        w_last_nxt    = r_last;
        w_illegal_nxt = r_illegal;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_valid_nxt   = 1'b1;
                    w_last_nxt    = 1'b1;
                    w_code_nxt    = w_dec_code;
                    w_illegal_nxt = w_dec_illegal;
                    w_right_nxt   = 1'b0;
                    w_cnt_nxt     = '0;
                    if (w_dec_is_lshi) begin
                        w_right_nxt = w_dir;
                        // zero-magnitude lshi stays a single 1000 beat
                        if (MULTI_STEP_SHIFT && (w_mag != '0)) begin
                            w_code_nxt = ALU_SHIFT1;
                            if (w_mag != SHAMT_W'(1)) begin
                                w_last_nxt  = 1'b0;
                                w_cnt_nxt   = w_mag - SHAMT_W'(1);
                                w_state_nxt = ST_SHIFT;
                            end
                        end
                    end
                end else if (w_xfer) begin
                    w_valid_nxt = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (w_xfer) begin
                    if (r_last) begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt  = r_cnt - SHAMT_W'(1);
                        w_last_nxt = (r_cnt == SHAMT_W'(1));
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign out_valid   = r_valid;
    assign alucont     = CTRL_W'(r_code);
    assign shift_right = r_right;
    assign out_last    = r_last;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: scoreboard of expected beats filled
// at acceptance and drained by a beat monitor, plus directed timing checks.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready;
    logic [3:0] opcode, opext;
    logic [4:0] imm;
    logic       out_valid, out_ready;
    logic [3:0] alucont;
    logic       shift_right, out_last, illegal;

    logic       b_in_valid, b_in_ready;
    logic [3:0] b_opcode, b_opext;
    logic [4:0] b_imm;
    logic       b_out_valid, b_out_ready;
    logic [3:0] b_alucont;
    logic       b_shift_right, b_out_last, b_illegal;

    int n_checks = 0;
    int n_fail   = 0;
    int n_beats  = 0;

    typedef struct packed {
        logic [3:0] code;
        logic       right;
        logic       last;
        logic       ill;
    } beat_t;

    beat_t exp_q[$];
    beat_t m_exp, m_act;

    always #5 clk = ~clk;

    alu_ctrl_seq #(
        .OP_W(4), .EXT_W(4), .CTRL_W(4), .SHAMT_W(4), .MULTI_STEP_SHIFT(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .opext(opext), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .alucont(alucont), .shift_right(shift_right),
        .out_last(out_last), .illegal(illegal)
    );

    alu_ctrl_seq #(
        .OP_W(4), .EXT_W(4), .CTRL_W(4), .SHAMT_W(4), .MULTI_STEP_SHIFT(1'b0)
    ) dut_single (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .opcode(b_opcode), .opext(b_opext), .imm(b_imm),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .alucont(b_alucont), .shift_right(b_shift_right),
        .out_last(b_out_last), .illegal(b_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference decode: {is_lshi, illegal, code}
    function automatic logic [5:0] ref_dec(input logic [3:0] op, input logic [3:0] ext);
        logic [3:0] f;
        f = (op == 4'b0000) ? ext : op;
        if (op == 4'b0000 && ext == 4'b0100) return 6'b00_1111;
        if (op == 4'b1000) return (ext == 4'b0100) ? 6'b00_0111 : 6'b10_1000;
        if (op == 4'b1111) return 6'b00_1001;
        case (f)
            4'b0101: return 6'b00_0000;
            4'b1001: return 6'b00_0001;
            4'b0001: return 6'b00_0010;
            4'b0011: return 6'b00_0011;
            4'b0010: return 6'b00_0100;
            4'b1011: return 6'b00_0101;
            4'b1101: return 6'b00_0110;
            default: return 6'b01_0000;
        endcase
    endfunction

    task automatic push_expected(input logic [3:0] op, input logic [3:0] ext, input logic [4:0] im);
        logic [5:0] d;
        int         n;
        beat_t      b;
        d = ref_dec(op, ext);
        n = int'(im[3:0]);
        if (d[5]) begin
            if (n >= 1) begin
                for (int k = 1; k <= n; k++) begin
                    b = {4'b1010, im[4], (k == n), 1'b0};
                    exp_q.push_back(b);
                end
            end else begin
                b = {4'b1000, im[4], 1'b1, 1'b0};
                exp_q.push_back(b);
            end
        end else begin
            b = {d[3:0], 1'b0, 1'b1, d[4]};
            exp_q.push_back(b);
        end
    endtask

    // Beat monitor: every transferred beat must match the scoreboard head
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_beats++;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                m_exp = exp_q.pop_front();
                m_act = {alucont, shift_right, out_last, illegal};
                chk("beat", 32'(m_act), 32'(m_exp));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge
    task automatic send(input logic [3:0] op, input logic [3:0] ext, input logic [4:0] im,
                        input int exp_wait);
        int t;
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        opcode   = op;
        opext    = ext;
        imm      = im;
        for (t = 0; t < 60; t++) begin
            @(negedge clk);
            if (in_ready) begin
                push_expected(op, ext, im);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
        else if (exp_wait >= 0) chk("accept_wait", 32'(t), 32'(exp_wait));
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        reset = 1'b0; in_valid = 1'b0; opcode = '0; opext = '0; imm = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_opcode = '0; b_opext = '0; b_imm = '0; b_out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid",   32'(out_valid),   32'd0);
        chk("rst_alucont",     32'(alucont),     32'd0);
        chk("rst_shift_right", 32'(shift_right), 32'd0);
        chk("rst_out_last",    32'(out_last),    32'd0);
        chk("rst_illegal",     32'(illegal),     32'd0);
        chk("rst_in_ready",    32'(in_ready),    32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // addi: first beat valid the cycle after acceptance
        send(4'b0101, 4'b0000, 5'b00000, 0);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_code",  32'(alucont),   32'd0);
        chk("lat_last",  32'(out_last),  32'd1);

        // back-to-back single beats, no bubble
        send(4'b0000, 4'b0100, 5'b00000, 0);
        send(4'b1011, 4'b0000, 5'b00000, 0);

        // 3-step right shift, then in_ready low until its last beat goes
        send(4'b1000, 4'b0000, 5'b10011, 0);
        send(4'b1000, 4'b0000, 5'b00000, 3);
        send(4'b1000, 4'b0100, 5'b01111, 0);

        // illegal opcode / R-type function
        send(4'b0111, 4'b0000, 5'b00000, 0);
        send(4'b0000, 4'b1111, 5'b00000, 0);

        // decode sweep with random opext/imm
        for (int i = 0; i < 16; i++) send(4'(i), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), -1);
        for (int i = 0; i < 16; i++) send(4'b0000, 4'(i), 5'($urandom_range(0, 31)), -1);

        // maximum magnitude
        drain();
        b0 = n_beats;
        send(4'b1000, 4'b0011, 5'b01111, 0);
        drain();
        chk("max_beats", 32'(n_beats - b0), 32'd15);

        // stall during second beat of a 5-step left shift
        b0 = n_beats;
        send(4'b1000, 4'b0000, 5'b00101, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("stall_hold", 32'({out_valid, alucont, shift_right, out_last, illegal, in_ready}),
                32'(9'b1_1010_0_0_0_0));
        end
        out_ready = 1'b1;
        drain();
        chk("stall_beats", 32'(n_beats - b0), 32'd5);

        // reset mid-sequence aborts the shift
        send(4'b1000, 4'b0000, 5'b10111, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_quiet", 32'(out_valid), 32'd0);

        // recovery after abort
        send(4'b1111, 4'b0000, 5'b00000, 0);
        drain();

        // single-beat build: lshi is never expanded
        b_in_valid = 1'b1; b_opcode = 4'b1000; b_opext = 4'b0000; b_imm = 5'b01111;
        chk("s_in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        #1;
        b_imm = 5'b10110;
        chk("s_beat0", 32'({b_out_valid, b_alucont, b_shift_right, b_out_last, b_illegal}),
            32'(8'b1_1000_0_1_0));
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("s_beat1", 32'({b_out_valid, b_alucont, b_shift_right, b_out_last, b_illegal}),
            32'(8'b1_1000_1_1_0));
        @(posedge clk);
        #1;
        chk("s_idle", 32'(b_out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
